// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter that consumes one control token per cycle and issues the
// winner's compile-time constant and index through a one-slot registered buffer.
module handshake_constant_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS =
    128'h00000040_00000030_00000020_00000010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_idx,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = NUM_REQ[IDX_WIDTH:0];
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

  logic [DATA_WIDTH-1:0] r_outs;
  logic [IDX_WIDTH-1:0]  r_outsIdx;
  logic                  r_outsValid;
  logic [IDX_WIDTH-1:0]  r_ptr;

  logic                  w_loadEn;
  logic                  w_found;
  logic [IDX_WIDTH-1:0]  w_win;
  logic [IDX_WIDTH:0]    w_sum;
  logic [NUM_REQ-1:0]    w_ready;
  logic [IDX_WIDTH-1:0]  w_ptrNext;

  assign w_loadEn = !r_outsValid || outs_ready;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid candidate wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + k[IDX_WIDTH:0];
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      if (!w_found && ctrl_valid[w_sum[IDX_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDX_WIDTH-1:0];
      end
    end
  end

  // Grant is withheld during reset so no token is consumed and then discarded.
  always_comb begin
    w_ready = '0;
    if (w_loadEn && w_found && !rst) begin
      w_ready[w_win] = 1'b1;
    end
  end

  assign w_ptrNext = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outs      <= '0;
      r_outsIdx   <= '0;
      r_outsValid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_loadEn) begin
      if (w_found) begin
        r_outs      <= CONSTS[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_outsIdx   <= w_win;
        r_outsValid <= 1'b1;
        r_ptr       <= w_ptrNext;
      end else begin
        r_outsValid <= 1'b0;
      end
    end
  end

  assign ctrl_ready = w_ready;
  assign outs       = r_outs;
  assign outs_idx   = r_outsIdx;
  assign outs_valid = r_outsValid;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter: a default 4-requester instance
// plus a 3-requester instance exercising pointer wrap with a non-power-of-two count.
module tb_handshake_constant_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  cv;
  logic [3:0]  cr;
  logic [31:0] outsA;
  logic [1:0]  idxA;
  logic        ovA;
  logic        ordy;

  logic [2:0]  cvB;
  logic [2:0]  crB;
  logic [31:0] outsB;
  logic [1:0]  idxB;
  logic        ovB;
  logic        ordyB;

  int errors;
  int checks;

  handshake_constant_arbiter dutA (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (cv),
    .ctrl_ready (cr),
    .outs       (outsA),
    .outs_idx   (idxA),
    .outs_valid (ovA),
    .outs_ready (ordy)
  );

  handshake_constant_arbiter #(
    .DATA_WIDTH (32),
    .NUM_REQ    (3),
    .IDX_WIDTH  (2),
    .CONSTS     (96'h00000300_00000200_00000100)
  ) dutB (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (cvB),
    .ctrl_ready (crB),
    .outs       (outsB),
    .outs_idx   (idxB),
    .outs_valid (ovB),
    .outs_ready (ordyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    cv   = valid;
    ordy = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] idx);
    checkOutput({tag, "_valid"}, {31'd0, ovA}, {31'd0, v});
    checkOutput({tag, "_outs"}, outsA, d);
    checkOutput({tag, "_idx"}, {30'd0, idxA}, {30'd0, idx});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    cvB    = 3'b000;
    ordyB  = 1'b1;
    applyStimulus(4'b1111, 1'b1);

    // Reset held two cycles with every requester valid.
    checkOutput("rst_ready0", {28'd0, cr}, 32'h0);
    tick();
    checkA("rst1", 1'b0, 32'h0, 2'd0);
    checkOutput("rst_ready1", {28'd0, cr}, 32'h0);
    tick();
    checkA("rst2", 1'b0, 32'h0, 2'd0);
    checkOutput("rst_ready2", {28'd0, cr}, 32'h0);

    // Round-robin with all valid: 0,1,2,3,0,1 back to back.
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_ready0", {28'd0, cr}, 32'h1);
    tick(); checkA("rr0", 1'b1, 32'h10, 2'd0);
    checkOutput("rr_ready1", {28'd0, cr}, 32'h2);
    tick(); checkA("rr1", 1'b1, 32'h20, 2'd1);
    checkOutput("rr_ready2", {28'd0, cr}, 32'h4);
    tick(); checkA("rr2", 1'b1, 32'h30, 2'd2);
    checkOutput("rr_ready3", {28'd0, cr}, 32'h8);
    tick(); checkA("rr3", 1'b1, 32'h40, 2'd3);
    tick(); checkA("rr4", 1'b1, 32'h10, 2'd0);
    tick(); checkA("rr5", 1'b1, 32'h20, 2'd1);

    // Backpressure: req1's token holds, no grants while stalled.
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_ready", {28'd0, cr}, 32'h0);
      tick();
      checkA("bp_hold", 1'b1, 32'h20, 2'd1);
    end
    applyStimulus(4'b1111, 1'b1);
    checkOutput("bp_release_ready", {28'd0, cr}, 32'h4);
    tick();
    checkA("bp_drain_load", 1'b1, 32'h30, 2'd2);

    // Single requester (pointer now at 3): req2 only, for one cycle.
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_ready", {28'd0, cr}, 32'h4);
    tick();
    checkA("single_out", 1'b1, 32'h30, 2'd2);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_ready", {28'd0, cr}, 32'h0);
    tick();
    checkOutput("single_empty", {31'd0, ovA}, 32'h0);
    tick();
    checkOutput("idle_empty", {31'd0, ovA}, 32'h0);

    // Pointer must not have moved on idle cycles: req3 is next.
    applyStimulus(4'b1111, 1'b1);
    checkOutput("ptr_hold_ready", {28'd0, cr}, 32'h8);
    tick();
    checkA("ptr_hold", 1'b1, 32'h40, 2'd3);

    // Reset mid-stream discards the buffered req3 token and restarts at req0.
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("mid_rst_ready", {28'd0, cr}, 32'h0);
    tick();
    checkA("mid_rst", 1'b0, 32'h0, 2'd0);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("post_rst_ready", {28'd0, cr}, 32'h1);
    tick();
    checkA("post_rst", 1'b1, 32'h10, 2'd0);
    applyStimulus(4'b0000, 1'b1);

    // Three requesters: grant req1 to park the pointer at 2, then 2,0,2,0.
    cvB = 3'b010;
    #1;
    checkOutput("wrap_ready_pre", {29'd0, crB}, 32'h2);
    tick();
    checkOutput("wrap_pre_idx", {30'd0, idxB}, 32'h1);
    checkOutput("wrap_pre_outs", outsB, 32'h200);
    cvB = 3'b101;
    #1;
    checkOutput("wrap_ready0", {29'd0, crB}, 32'h4);
    tick();
    checkOutput("wrap_idx0", {30'd0, idxB}, 32'h2);
    checkOutput("wrap_outs0", outsB, 32'h300);
    checkOutput("wrap_ready1", {29'd0, crB}, 32'h1);
    tick();
    checkOutput("wrap_idx1", {30'd0, idxB}, 32'h0);
    checkOutput("wrap_outs1", outsB, 32'h100);
    checkOutput("wrap_ready2", {29'd0, crB}, 32'h4);
    tick();
    checkOutput("wrap_idx2", {30'd0, idxB}, 32'h2);
    checkOutput("wrap_ready3", {29'd0, crB}, 32'h1);
    tick();
    checkOutput("wrap_idx3", {30'd0, idxB}, 32'h0);
    checkOutput("wrap_valid3", {31'd0, ovB}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
